// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter: op encoding and
// the split of shift levels across pipe stages.
package shifter_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ROL = 3'b000,
    OP_SLL = 3'b001,
    OP_ROR = 3'b010,
    OP_SRL = 3'b011,
    OP_SRA = 3'b100
  } shift_op_t;

  // First level handled by a stage; earlier stages absorb the remainder levels.
  // The level range of stage k is [stage_lvl_lo(k), stage_lvl_lo(k+1)).
  function automatic int stage_lvl_lo(input int stage, input int levels, input int stages);
    int base;
    int rem;
    base = levels / stages;
    rem  = levels % stages;
    return stage * base + ((stage < rem) ? stage : rem);
  endfunction

endpackage

// File: rtl/pipelined_shifter_if.sv
// Operation/result handshake bundle of the pipelined shifter.
// Flag signals exist only when SHIFTER_FLAGS_EN is defined.
interface pipelined_shifter_if
  import shifter_pkg::*;
#(
  parameter int WIDTH = 16
);
  localparam int CNT_W = $clog2(WIDTH);

  // Both sides use strict valid/ready: a transfer happens on a rising clock
  // edge where valid && ready; a producer holding valid keeps its payload stable.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [CNT_W-1:0] in_cnt;
  logic [OP_W-1:0]  in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef SHIFTER_FLAGS_EN
  logic             out_cout;
  logic             out_zero;
`endif

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
`ifdef SHIFTER_FLAGS_EN
    output out_cout, out_zero,
`endif
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
`ifdef SHIFTER_FLAGS_EN
    input  out_cout, out_zero,
`endif
    input  in_ready, out_valid, out_data
  );

endinterface

// File: rtl/shifter_stage.sv
// One pipe stage of the shifter: applies shift levels [LVL_LO, LVL_HI) and
// registers the op with its own stall logic. Flags only with SHIFTER_FLAGS_EN.
module shifter_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH  = 16,
  parameter  int LVL_LO = 0,
  parameter  int LVL_HI = 1,
  localparam int CNT_W  = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid_i,
  output logic             up_ready_o,
  input  logic [WIDTH-1:0] up_data_i,
  input  logic [OP_W-1:0]  up_op_i,
  input  logic [CNT_W-1:0] up_cnt_i,
  input  logic             up_sign_i,
`ifdef SHIFTER_FLAGS_EN
  input  logic             up_cout_i,
  output logic             dn_cout_o,
  output logic             dn_zero_o,
`endif
  input  logic             dn_ready_i,
  output logic             dn_valid_o,
  output logic [WIDTH-1:0] dn_data_o,
  output logic [OP_W-1:0]  dn_op_o,
  output logic [CNT_W-1:0] dn_cnt_o,
  output logic             dn_sign_o
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

  logic             valid_q;
  logic [WIDTH-1:0] data_q, data_d;
  logic [OP_W-1:0]  op_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;
  logic             load;
`ifdef SHIFTER_FLAGS_EN
  logic             cout_q, cout_d;
  logic             zero_q;
  logic [WIDTH-1:0] lost;
`endif

  // The stage frees up in the same cycle it hands its op downstream.
  assign up_ready_o = !valid_q || dn_ready_i;
  assign load       = up_valid_i && up_ready_o;

  always_comb begin
    int  sh;
    logic cnt_bit;
    sh      = 0;
    cnt_bit = 1'b0;
    data_d  = up_data_i;
`ifdef SHIFTER_FLAGS_EN
    cout_d  = up_cout_i;
    lost    = '0;
`endif
    for (int i = LVL_LO; i < LVL_HI; i++) begin
      sh      = 1 << i;
      cnt_bit = |(up_cnt_i & (CNT_W'(1) << i));
      if (cnt_bit) begin
`ifdef SHIFTER_FLAGS_EN
        // The last bit out of the composite shift is the last bit out of its highest level.
        if (up_op_i inside {OP_ROL, OP_SLL}) begin
          lost   = data_d >> (WIDTH - sh);
          cout_d = lost[0];
        end else if (up_op_i inside {OP_ROR, OP_SRL, OP_SRA}) begin
          lost   = data_d >> (sh - 1);
          cout_d = lost[0];
        end
`endif
        case (up_op_i)
          OP_ROL:  data_d = (data_d << sh) | (data_d >> (WIDTH - sh));
          OP_SLL:  data_d = data_d << sh;
          OP_ROR:  data_d = (data_d >> sh) | (data_d << (WIDTH - sh));
          OP_SRL:  data_d = data_d >> sh;
          OP_SRA:  data_d = (data_d >> sh) | (up_sign_i ? ~(ONES >> sh) : '0);
          default: data_d = data_d;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      op_q    <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
`ifdef SHIFTER_FLAGS_EN
      cout_q  <= 1'b0;
      zero_q  <= 1'b0;
`endif
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_d;
      op_q    <= up_op_i;
      cnt_q   <= up_cnt_i;
      sign_q  <= up_sign_i;
`ifdef SHIFTER_FLAGS_EN
      cout_q  <= cout_d;
      zero_q  <= (data_d == '0);
`endif
    end else if (dn_ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign dn_valid_o = valid_q;
  assign dn_data_o  = data_q;
  assign dn_op_o    = op_q;
  assign dn_cnt_o   = cnt_q;
  assign dn_sign_o  = sign_q;
`ifdef SHIFTER_FLAGS_EN
  assign dn_cout_o  = cout_q;
  assign dn_zero_o  = zero_q;
`endif

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter (ROL/SLL/ROR/SRL/SRA) with valid/ready flow control.
// Define SHIFTER_FLAGS_EN to add the carry-out and zero result flags.
module pipelined_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  pipelined_shifter_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH);

  // Index k is the input of stage k; index PIPE_STAGES is the pipe output.
  logic             valid_w [PIPE_STAGES+1];
  logic             ready_w [PIPE_STAGES+1];
  logic [WIDTH-1:0] data_w  [PIPE_STAGES+1];
  logic [OP_W-1:0]  op_w    [PIPE_STAGES+1];
  logic [CNT_W-1:0] cnt_w   [PIPE_STAGES+1];
  logic             sign_w  [PIPE_STAGES+1];
  logic             unused_tail;

  assign valid_w[0]           = bus.in_valid;
  assign data_w[0]            = bus.in_data;
  assign op_w[0]              = bus.in_op;
  assign cnt_w[0]             = bus.in_cnt;
  assign sign_w[0]            = bus.in_data[WIDTH-1];
  assign ready_w[PIPE_STAGES] = bus.out_ready;
  assign bus.in_ready         = ready_w[0];
  assign bus.out_valid        = valid_w[PIPE_STAGES];
  assign bus.out_data         = data_w[PIPE_STAGES];

`ifdef SHIFTER_FLAGS_EN
  logic cout_w [PIPE_STAGES+1];
  logic zero_w [PIPE_STAGES+1];
  logic unused_zero;

  assign cout_w[0]    = 1'b0;
  assign zero_w[0]    = 1'b0;
  assign bus.out_cout = cout_w[PIPE_STAGES];
  assign bus.out_zero = zero_w[PIPE_STAGES];

  // Only the last stage's zero flag describes the final result.
  always_comb begin
    unused_zero = 1'b0;
    for (int k = 0; k < PIPE_STAGES; k++) unused_zero = unused_zero ^ zero_w[k];
  end
`endif

  assign unused_tail = ^{op_w[PIPE_STAGES], cnt_w[PIPE_STAGES], sign_w[PIPE_STAGES]};

  for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
    shifter_stage #(
      .WIDTH  (WIDTH),
      .LVL_LO (stage_lvl_lo(k, CNT_W, PIPE_STAGES)),
      .LVL_HI (stage_lvl_lo(k + 1, CNT_W, PIPE_STAGES))
    ) u_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .up_valid_i (valid_w[k]),
      .up_ready_o (ready_w[k]),
      .up_data_i  (data_w[k]),
      .up_op_i    (op_w[k]),
      .up_cnt_i   (cnt_w[k]),
      .up_sign_i  (sign_w[k]),
`ifdef SHIFTER_FLAGS_EN
      .up_cout_i  (cout_w[k]),
      .dn_cout_o  (cout_w[k+1]),
      .dn_zero_o  (zero_w[k+1]),
`endif
      .dn_ready_i (ready_w[k+1]),
      .dn_valid_o (valid_w[k+1]),
      .dn_data_o  (data_w[k+1]),
      .dn_op_o    (op_w[k+1]),
      .dn_cnt_o   (cnt_w[k+1]),
      .dn_sign_o  (sign_w[k+1])
    );
  end

endmodule

// File: tb/tb_pipelined_shifter.sv
// Directed bench for pipelined_shifter (WIDTH=16, PIPE_STAGES=2); flag checks
// are active when SHIFTER_FLAGS_EN is defined.
module tb_pipelined_shifter;
  import shifter_pkg::*;

  localparam int W  = 16;
  localparam int CW = 4;
  localparam int EW = W + 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_shifter_if #(.WIDTH(W)) bus ();

  pipelined_shifter #(.WIDTH(W), .PIPE_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_e;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver: presents one op from posedge+1, waits (bounded) for acceptance.
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d, input logic [CW-1:0] c,
                       input logic exp_cout, input logic [W-1:0] exp_res);
    int guard;
    guard        = 0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_data  = d;
    bus.in_cnt   = c;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready stuck at 0 for op %b data %h", op, d);
    end else begin
      exp_q.push_back({exp_res == '0, exp_cout, exp_res});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check_eq("drain_left", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every completed transfer is checked against the expected queue.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_out: got %h with no op pending", bus.out_data);
      end else begin
        exp_e = exp_q.pop_front();
        check_eq("out_data", bus.out_data, exp_e[W-1:0]);
`ifdef SHIFTER_FLAGS_EN
        check_eq("out_cout", bus.out_cout, exp_e[W]);
        check_eq("out_zero", bus.out_zero, exp_e[W+1]);
`endif
        n_out++;
      end
    end
  end

  initial begin
    int out_before;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_op     = '0;
    bus.in_data   = '0;
    bus.in_cnt    = '0;
    bus.out_ready = 1'b1;

    // Reset state
    #2;
    check_eq("rst_out_valid", bus.out_valid, 0);
    check_eq("rst_out_data", bus.out_data, 0);
`ifdef SHIFTER_FLAGS_EN
    check_eq("rst_out_cout", bus.out_cout, 0);
    check_eq("rst_out_zero", bus.out_zero, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("idle_in_ready", bus.in_ready, 1);

    // Latency: result visible exactly two cycles after the accepting cycle
    issue(3'b000, 16'h8001, 4'd1, 1'b1, 16'h0003);
    @(negedge clk);
    check_eq("lat_cycle1_valid", bus.out_valid, 0);
    @(negedge clk);
    check_eq("lat_cycle2_valid", bus.out_valid, 1);
    wait_drain();

    // Directed vectors, issued back to back
    issue(3'b100, 16'h8000, 4'd15, 1'b0, 16'hFFFF);
    issue(3'b011, 16'h8000, 4'd15, 1'b0, 16'h0001);
    issue(3'b011, 16'h1234, 4'd4,  1'b0, 16'h0123);
    issue(3'b001, 16'h00F0, 4'd12, 1'b1, 16'h0000);
    issue(3'b010, 16'hA5A5, 4'd0,  1'b0, 16'hA5A5);
    issue(3'b110, 16'h1234, 4'd5,  1'b0, 16'h1234);
    issue(3'b010, 16'h0001, 4'd1,  1'b1, 16'h8000);
    issue(3'b100, 16'h4000, 4'd3,  1'b0, 16'h0800);
    issue(3'b001, 16'h0001, 4'd15, 1'b0, 16'h8000);
    issue(3'b000, 16'h1234, 4'd4,  1'b1, 16'h2341);
    issue(3'b100, 16'hF000, 4'd4,  1'b0, 16'hFF00);
    issue(3'b011, 16'h00FF, 4'd8,  1'b1, 16'h0000);
    issue(3'b111, 16'h0000, 4'd3,  1'b0, 16'h0000);
    issue(3'b010, 16'h1234, 4'd8,  1'b0, 16'h3412);
    wait_drain();

    // Backpressure: A and B fill the pipe, C must wait, A holds at the output
    out_before    = n_out;
    bus.out_ready = 1'b0;
    issue(3'b001, 16'h0003, 4'd2, 1'b0, 16'h000C);
    issue(3'b011, 16'hF000, 4'd4, 1'b0, 16'h0F00);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'b000;
    bus.in_data  = 16'h00FF;
    bus.in_cnt   = 4'd8;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("bp_in_ready", bus.in_ready, 0);
      check_eq("bp_out_valid", bus.out_valid, 1);
      check_eq("bp_hold_data", bus.out_data, 16'h000C);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    issue(3'b000, 16'h00FF, 4'd8, 1'b0, 16'hFF00);
    wait_drain();
    check_eq("bp_out_count", n_out - out_before, 3);

    // Reset with two ops in flight: drop them, no output after release
    bus.out_ready = 1'b0;
    issue(3'b001, 16'h0001, 4'd1, 1'b0, 16'h0002);
    issue(3'b001, 16'h0001, 4'd2, 1'b0, 16'h0004);
    @(negedge clk);
    check_eq("pre_rst_valid", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", bus.out_valid, 0);
    check_eq("rst_async_data", bus.out_data, 0);
    exp_q.delete();
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_rst_idle", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    out_before = n_out;
    issue(3'b010, 16'h0001, 4'd1, 1'b1, 16'h8000);
    wait_drain();
    check_eq("post_rst_out_count", n_out - out_before, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
